// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch interface for pc_fetch_unit.
//   imem_req   : fetch request (fetch unit -> memory)
//   imem_addr  : word fetch address (fetch unit -> memory)
//   imem_ready : memory returns imem_rdata this cycle (memory -> fetch unit)
//   imem_rdata : fetched instruction word (memory -> fetch unit)
// master = fetch unit side, slave = instruction memory side.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Holds the PC, issues word fetches over a req/ready handshake and selects
// the next PC (pc+4, branch target, jump target or a queued redirect).
//
// Ports:
//   clock          system clock, rising-edge
//   reset          synchronous active-high reset
//   stall          hazard stall, blocks PC advance
//   branch_taken   one-cycle redirect request to branch_target
//   branch_target  branch destination
//   jump           one-cycle redirect request to jump_target (wins over branch)
//   jump_target    jump destination
//   imem           instruction-memory interface (master side)
//   instr          last fetched instruction (registered)
//   instr_valid    one-cycle pulse when instr updates
//   pc             address of the instruction in flight
//   pc_plus4       pc + 4, mod 2^32
//   misalign       only when PC_ALIGN_CHECK_EN is defined: one-cycle pulse
//                  after a misaligned redirect request (which is discarded)
//
// Build option: define PC_ALIGN_CHECK_EN to discard misaligned redirect
// targets and flag them on misalign; otherwise target bits [1:0] are forced
// to zero.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jump,
  input  logic [31:0]            jump_target,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                   misalign
`endif
);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        req;
  logic        advance;
  logic        pending;
  logic [31:0] redirect_pc;

  logic        jump_ok, branch_ok;
  logic [31:0] jump_tgt, branch_tgt;
  logic        redir_req;
  logic [31:0] redir_tgt;
  logic [31:0] pc_next;
`ifdef PC_ALIGN_CHECK_EN
  logic        bad_redirect;
`endif

  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  // Redirect qualification. Jump takes precedence over branch among the
  // requests that survive alignment handling.
  always_comb begin
`ifdef PC_ALIGN_CHECK_EN
    jump_tgt     = jump_target;
    branch_tgt   = branch_target;
    jump_ok      = jump && (jump_target[1:0] == 2'b00);
    branch_ok    = branch_taken && (branch_target[1:0] == 2'b00);
    bad_redirect = (state != RST_HOLD) &&
                   ((jump && (jump_target[1:0] != 2'b00)) ||
                    (branch_taken && (branch_target[1:0] != 2'b00)));
`else
    jump_tgt     = jump_target & ~32'h3;
    branch_tgt   = branch_target & ~32'h3;
    jump_ok      = jump;
    branch_ok    = branch_taken;
`endif
    redir_req = (state != RST_HOLD) && (jump_ok || branch_ok);
    redir_tgt = jump_ok ? jump_tgt : branch_tgt;
  end

  always_comb begin
    if (jump_ok)
      pc_next = jump_tgt;
    else if (branch_ok)
      pc_next = branch_tgt;
    else if (pending)
      pc_next = redirect_pc;
    else
      pc_next = pc_plus4;
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= RST_HOLD;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    advance    = 1'b0;
    case (state)
      RST_HOLD: state_next = FETCH;
      FETCH: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          if (stall)
            state_next = HOLD;
          else
            advance = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = RST_HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      pending     <= 1'b0;
      redirect_pc <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      if ((state == FETCH) && imem.imem_ready) begin
        instr       <= imem.imem_rdata;
        instr_valid <= 1'b1;
      end
      if (advance) begin
        pc      <= pc_next;
        pending <= 1'b0;
      end else if (redir_req) begin
        pending     <= 1'b1;
        redirect_pc <= redir_tgt;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset)
      misalign <= 1'b0;
    else
      misalign <= bad_redirect;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int unsigned tests  = 0;
  int unsigned failed = 0;

  pc_fetch_unit_if imem ();

  pc_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem          (imem.master),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign      (misalign)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    imem.imem_ready = 1'b1; imem.imem_rdata = '0;

    // T1 reset
    step(); step();
    check("rst_pc",    pc, 32'h0040_0000);
    check("rst_req",   {31'd0, imem.imem_req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
    check("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
    reset = 1'b0;
    step();
    check("t1_req1",  {31'd0, imem.imem_req}, 32'd1);
    check("t1_addr0", imem.imem_addr, 32'h0040_0000);
    imem.imem_rdata = 32'hA5A5_0001;
    step();
    check("t1_addr1",  imem.imem_addr, 32'h0040_0004);
    check("t1_instr",  instr, 32'hA5A5_0001);
    check("t1_valid",  {31'd0, instr_valid}, 32'd1);
    step();
    check("t1_addr2",  imem.imem_addr, 32'h0040_0008);

    // T2 wait states at 0x10
    jump = 1'b1; jump_target = 32'h10;
    step();
    jump = 1'b0;
    check("t2_pc", pc, 32'h10);
    imem.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_wait_addr",  imem.imem_addr, 32'h10);
      check("t2_wait_valid", {31'd0, instr_valid}, 32'd0);
      check("t2_wait_req",   {31'd0, imem.imem_req}, 32'd1);
    end
    imem.imem_ready = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    step();
    check("t2_instr", instr, 32'hDEAD_BEEF);
    check("t2_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_next",  imem.imem_addr, 32'h14);
    imem.imem_ready = 1'b0;
    step();
    check("t2_pulse", {31'd0, instr_valid}, 32'd0);
    check("t2_hold",  pc, 32'h14);

    // T3 queued branch overwritten by a later jump
    imem.imem_ready = 1'b1; jump = 1'b1; jump_target = 32'h20;
    step();
    jump = 1'b0; imem.imem_ready = 1'b0;
    check("t3_pc", pc, 32'h20);
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    check("t3_wait1", pc, 32'h20);
    jump = 1'b1; jump_target = 32'h200;
    step();
    jump = 1'b0;
    check("t3_wait2", pc, 32'h20);
    imem.imem_ready = 1'b1;
    step();
    check("t3_redirect", imem.imem_addr, 32'h200);
    step();
    check("t3_cleared", imem.imem_addr, 32'h204);

    // jump and branch in the same advance cycle: jump wins
    jump = 1'b1; jump_target = 32'h300;
    branch_taken = 1'b1; branch_target = 32'h500;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    check("prio_jump", pc, 32'h300);

    // T4 stall on the ready cycle at 0x30
    jump = 1'b1; jump_target = 32'h30;
    step();
    jump = 1'b0;
    check("t4_pc", pc, 32'h30);
    stall = 1'b1; imem.imem_rdata = 32'h1234_5678;
    step();
    check("t4_hold_req",   {31'd0, imem.imem_req}, 32'd0);
    check("t4_hold_pc",    pc, 32'h30);
    check("t4_hold_instr", instr, 32'h1234_5678);
    check("t4_hold_valid", {31'd0, instr_valid}, 32'd1);
    step();
    check("t4_hold2_req",   {31'd0, imem.imem_req}, 32'd0);
    check("t4_hold2_pc",    pc, 32'h30);
    check("t4_hold2_valid", {31'd0, instr_valid}, 32'd0);
    stall = 1'b0;
    step();
    check("t4_release_addr", imem.imem_addr, 32'h34);
    check("t4_release_req",  {31'd0, imem.imem_req}, 32'd1);

    // T5 wrap-around
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    check("t5_pc",     pc, 32'hFFFF_FFFC);
    check("t5_plus4",  pc_plus4, 32'h0000_0000);
    step();
    check("t5_wrap",   imem.imem_addr, 32'h0000_0000);

    // T6 misaligned jump at 0x40
    jump = 1'b1; jump_target = 32'h40;
    step();
    check("t6_pc", pc, 32'h40);
    jump_target = 32'h203;
    step();
    jump = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    check("t6_addr",     imem.imem_addr, 32'h44);
    check("t6_misalign", {31'd0, misalign}, 32'd1);
    step();
    check("t6_misalign_pulse", {31'd0, misalign}, 32'd0);
`else
    check("t6_addr", imem.imem_addr, 32'h200);
`endif

    // Reset mid-fetch with a queued redirect, then a redirect during RST_HOLD
    imem.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h700;
    step();
    branch_taken = 1'b0;
    reset = 1'b1;
    step();
    check("mid_rst_req", {31'd0, imem.imem_req}, 32'd0);
    check("mid_rst_pc",  pc, 32'h0040_0000);
    reset = 1'b0; jump = 1'b1; jump_target = 32'h800;
    step();
    jump = 1'b0;
    check("rsthold_ignore_pc", pc, 32'h0040_0000);
    imem.imem_ready = 1'b1;
    step();
    check("rst_discard", imem.imem_addr, 32'h0040_0004);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
